// File: rtl/featuremap_channel_packer_pkg.sv
// Shared constants, lane helper and FSM encoding
// for the featuremap channel packer and its layer.
package featuremap_pkg;

    localparam int FP_WIDTH     = 32;
    localparam int LAYER_NUM_CH = 32;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } fm_state_t;

    function automatic int lane_lsb(input int k);
        return k * FP_WIDTH;
    endfunction

endpackage

// File: rtl/featuremap_channel_packer_if.sv
// Channel-serial input bus and packed pixel output bus
// of the featuremap channel packer.
interface featuremap_channel_packer_if
    import featuremap_pkg::*;
#(
    parameter int DATA_WIDTH = FP_WIDTH,
    parameter int NUM_CH     = LAYER_NUM_CH,
    parameter int IMG_SIZE   = 104
);
    localparam int PW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;

    logic [DATA_WIDTH-1:0]        data_in;
    logic                         valid_in;
    logic                         sof_in;
    logic [NUM_CH*DATA_WIDTH-1:0] data_out;
    logic                         valid_out;
    logic [PW-1:0]                col_out;
    logic [PW-1:0]                row_out;
    logic                         frame_done;
    logic                         sync_err;

    modport master (
        output data_in, valid_in, sof_in,
        input  data_out, valid_out, col_out, row_out,
        input  frame_done, sync_err
    );

    modport slave (
        input  data_in, valid_in, sof_in,
        output data_out, valid_out, col_out, row_out,
        output frame_done, sync_err
    );

endinterface

// File: rtl/featuremap_channel_packer_raster_counter.sv
// Raster col/row counter with wrap, synchronous clear
// and a registered end-of-frame pulse.
module featuremap_raster_counter #(
    parameter int IMG_SIZE = 104,
    parameter int PW       = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [PW-1:0] col,
    output logic [PW-1:0] row,
    output logic          wrap,
    output logic          frame_done
);
    localparam logic [PW-1:0] MAX = PW'(IMG_SIZE - 1);

    logic [PW-1:0] base_col;
    logic [PW-1:0] base_row;

    // A clear takes effect before any advance in the same cycle
    always_comb begin
        base_col = clr ? '0 : col;
        base_row = clr ? '0 : row;
        wrap     = adv & (base_col == MAX) & (base_row == MAX);
    end

    // Step through raster order, restarting after the last pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (wrap) begin
                col <= '0;
                row <= '0;
            end else if (adv) begin
                if (base_col == MAX) begin
                    col <= '0;
                    row <= base_row + 1'b1;
                end else begin
                    col <= base_col + 1'b1;
                    row <= base_row;
                end
            end else if (clr) begin
                col <= '0;
                row <= '0;
            end
        end
    end

endmodule

// File: rtl/featuremap_channel_packer.sv
// Packs a channel-serial fp32 stream into one vector
// per pixel, tracking raster position and stream sync.
module featuremap_channel_packer
    import featuremap_pkg::*;
#(
    parameter int DATA_WIDTH = FP_WIDTH,
    parameter int NUM_CH     = LAYER_NUM_CH,
    parameter int IMG_SIZE   = 104
) (
    input  logic Clk,
    input  logic Rst,
    featuremap_channel_packer_if.slave bus
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
    localparam int BW = NUM_CH * DATA_WIDTH;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

    fm_state_t     state;
    logic [CW-1:0] ch_cnt;
    logic [CW-1:0] eff;
    logic [BW-1:0] asm_q;
    logic [BW-1:0] asm_d;
    logic [PW-1:0] col;
    logic [PW-1:0] row;
    logic          accept;
    logic          restart;
    logic          resync;
    logic          drop;
    logic          complete;
    logic          wrap;

    // Classify the incoming word; an sof always lands in lane 0
    always_comb begin
        restart  = bus.valid_in & bus.sof_in;
        accept   = bus.valid_in & ((state == COLLECT) | bus.sof_in);
        drop     = bus.valid_in & ~bus.sof_in & (state == IDLE);
        resync   = restart & (state == COLLECT)
                 & ((ch_cnt != '0) | (col != '0) | (row != '0));
        eff      = restart ? '0 : ch_cnt;
        complete = accept & (eff == LAST_CH);
    end

    // Assembly buffer with the incoming word merged into its lane
    always_comb begin
        asm_d = asm_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (eff == CW'(k)) begin
                asm_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.data_in;
            end
        end
    end

    featuremap_raster_counter #(
        .IMG_SIZE (IMG_SIZE),
        .PW       (PW)
    ) u_raster (
        .clk        (Clk),
        .rst        (Rst),
        .clr        (resync),
        .adv        (complete),
        .col        (col),
        .row        (row),
        .wrap       (wrap),
        .frame_done (bus.frame_done)
    );

    // Channel sequencing, pixel publication and frame FSM
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state         <= IDLE;
            ch_cnt        <= '0;
            asm_q         <= '0;
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
            bus.col_out   <= '0;
            bus.row_out   <= '0;
            bus.sync_err  <= 1'b0;
        end else begin
            bus.valid_out <= complete;
            bus.sync_err  <= resync | drop;
            if (accept) begin
                asm_q  <= asm_d;
                ch_cnt <= complete ? '0 : eff + 1'b1;
            end
            if (complete) begin
                bus.data_out <= asm_d;
                bus.col_out  <= resync ? '0 : col;
                bus.row_out  <= resync ? '0 : row;
            end
            if (complete & wrap) begin
                state <= IDLE;
            end else if (accept) begin
                state <= COLLECT;
            end
        end
    end

endmodule

// File: tb/tb_featuremap_channel_packer.sv
// Self-checking bench: vector table, directed corner
// sequences and a queue-based pixel reference model.
module tb_featuremap_channel_packer;
    import featuremap_pkg::*;

    localparam int DW = 32;
    localparam int NC = 32;
    localparam int IS = 4;
    localparam int PW = 2;
    localparam int BW = NC * DW;

    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    featuremap_channel_packer_if #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NC),
        .IMG_SIZE   (IS)
    ) bus ();

    featuremap_channel_packer #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NC),
        .IMG_SIZE   (IS)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_fd = 0;
    int n_se = 0;

    // reference model state: frame membership, words of current pixel, pixel index
    bit          in_frame;
    logic [31:0] words[$];
    int          pix;
    bit          e_v;
    bit          e_se;
    bit          e_fd;
    logic [BW-1:0] e_data;
    logic [PW-1:0] e_col;
    logic [PW-1:0] e_row;

    typedef struct {
        bit          v;
        bit          s;
        logic [31:0] d;
        bit          ev;
        bit          ese;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [BW-1:0] act,
                       input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model(input bit rst, input bit v, input bit s,
                         input logic [31:0] d);
        e_v  = 1'b0;
        e_se = 1'b0;
        e_fd = 1'b0;
        if (rst) begin
            in_frame = 1'b0;
            words.delete();
            pix    = 0;
            e_data = '0;
            e_col  = '0;
            e_row  = '0;
        end else if (v) begin
            if (s) begin
                if (in_frame && (words.size() != 0 || pix != 0)) e_se = 1'b1;
                in_frame = 1'b1;
                words.delete();
                pix = 0;
            end
            if (!in_frame) begin
                e_se = 1'b1;
            end else begin
                words.push_back(d);
                if (words.size() == NC) begin
                    e_v = 1'b1;
                    for (int k = 0; k < NC; k++) e_data[lane_lsb(k) +: 32] = words[k];
                    e_col = PW'(pix % IS);
                    e_row = PW'(pix / IS);
                    words.delete();
                    pix++;
                    if (pix == IS * IS) begin
                        e_fd     = 1'b1;
                        pix      = 0;
                        in_frame = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit v, input bit s,
                        input logic [31:0] d);
        Rst          = rst;
        bus.valid_in = v;
        bus.sof_in   = s;
        bus.data_in  = d;
        model(rst, v, s, d);
        @(posedge Clk);
        #1;
        chk("valid_out", BW'(bus.valid_out), BW'(e_v));
        chk("sync_err", BW'(bus.sync_err), BW'(e_se));
        chk("frame_done", BW'(bus.frame_done), BW'(e_fd));
        chk("data_out", bus.data_out, e_data);
        chk("col_out", BW'(bus.col_out), BW'(e_col));
        chk("row_out", BW'(bus.row_out), BW'(e_row));
        if (bus.valid_out) n_valid++;
        if (bus.frame_done) n_fd++;
        if (bus.sync_err) n_se++;
    endtask

    task automatic pat_word(input int p, input int ch, output logic [31:0] w);
        logic [15:0] ph;
        logic [15:0] cl;
        ph = 16'(p);
        cl = 16'(ch);
        w  = {ph, cl};
    endtask

    initial begin
        int v0;
        int f0;
        int s0;
        logic [31:0] w;
        logic [31:0] rs_word;

        Rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.sof_in   = 1'b0;
        bus.data_in  = '0;

        tbl[0] = '{1'b1, 1'b0, 32'hA5A5_0001, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 32'hA5A5_0002, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 32'hA5A5_0003, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0};

        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        chk("reset_data_out", bus.data_out, '0);
        chk("reset_valid_out", BW'(bus.valid_out), '0);

        // words without sof in IDLE are dropped
        for (int i = 0; i < 6; i++) begin
            step(1'b0, tbl[i].v, tbl[i].s, tbl[i].d);
            chk("tbl_valid_out", BW'(bus.valid_out), BW'(tbl[i].ev));
            chk("tbl_sync_err", BW'(bus.sync_err), BW'(tbl[i].ese));
            chk("tbl_data_out", bus.data_out, '0);
        end
        chk("idle_sync_err_count", BW'(n_se), BW'(3));

        // one patterned frame
        v0 = n_valid;
        f0 = n_fd;
        for (int p = 0; p < IS * IS; p++) begin
            for (int ch = 0; ch < NC; ch++) begin
                pat_word(p, ch, w);
                step(1'b0, 1'b1, (p == 0 && ch == 0), w);
            end
            pat_word(p, 5, w);
            chk("frame1_lane5", BW'(bus.data_out[lane_lsb(5) +: 32]), BW'(w));
        end
        chk("frame1_pixels", BW'(n_valid - v0), BW'(16));
        chk("frame1_done", BW'(n_fd - f0), BW'(1));

        // two back-to-back random frames
        v0 = n_valid;
        f0 = n_fd;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < IS * IS * NC; i++) begin
                step(1'b0, 1'b1, (i == 0), $urandom);
            end
        end
        chk("frames2_pixels", BW'(n_valid - v0), BW'(32));
        chk("frames2_done", BW'(n_fd - f0), BW'(2));

        // sof on channel word 10 of pixel 5
        s0 = n_se;
        for (int i = 0; i < 5 * NC + 10; i++) begin
            pat_word(i / NC, i % NC, w);
            step(1'b0, 1'b1, (i == 0), w);
        end
        rs_word = 32'hC0DE_0000;
        step(1'b0, 1'b1, 1'b1, rs_word);
        chk("resync_err", BW'(n_se - s0), BW'(1));
        for (int ch = 1; ch < NC; ch++) begin
            step(1'b0, 1'b1, 1'b0, rs_word + 32'(ch));
        end
        chk("resync_valid", BW'(bus.valid_out), BW'(1));
        chk("resync_col", BW'(bus.col_out), '0);
        chk("resync_row", BW'(bus.row_out), '0);
        chk("resync_lane0", BW'(bus.data_out[31:0]), BW'(rs_word));
        chk("resync_lane31", BW'(bus.data_out[lane_lsb(31) +: 32]), BW'(rs_word + 32'd31));
        for (int i = NC; i < IS * IS * NC; i++) begin
            step(1'b0, 1'b1, 1'b0, $urandom);
        end

        // 50% random gaps inside pixels
        v0 = n_valid;
        for (int p = 0; p < IS * IS; p++) begin
            for (int ch = 0; ch < NC; ch++) begin
                while ($urandom_range(0, 1) == 1) begin
                    step(1'b0, 1'b0, 1'b0, $urandom);
                end
                pat_word(p, ch, w);
                step(1'b0, 1'b1, (p == 0 && ch == 0), w);
            end
            pat_word(p, NC - 1, w);
            chk("gap_lane31", BW'(bus.data_out[lane_lsb(31) +: 32]), BW'(w));
        end
        chk("gap_pixels", BW'(n_valid - v0), BW'(16));

        // reset after 20 words of a pixel
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, (i == 0), 32'hBAD0_0000 + 32'(i));
        end
        step(1'b1, 1'b0, 1'b0, '0);
        chk("rst_mid_data", bus.data_out, '0);
        chk("rst_mid_col", BW'(bus.col_out), '0);
        for (int i = 0; i < 2 * NC; i++) begin
            step(1'b0, 1'b1, (i == 0), 32'h5EED_0000 + 32'(i));
        end
        chk("post_rst_col", BW'(bus.col_out), BW'(1));
        chk("post_rst_lane0", BW'(bus.data_out[31:0]), BW'(32'h5EED_0000 + 32'(NC)));
        step(1'b0, 1'b0, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
